// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU phase sequencer: run/halt state,
// the FETCH phase index and the legal range of N_PHASES.
package cpu_seq_pkg;

    typedef enum logic {
        SEQ_RUN    = 1'b0,
        SEQ_HALTED = 1'b1
    } seq_state_e;

    localparam int unsigned PH_FETCH     = 0;
    localparam int unsigned N_PHASES_MIN = 2;
    localparam int unsigned N_PHASES_MAX = 8;

    function automatic bit n_phases_legal(input int unsigned n);
        return (n >= N_PHASES_MIN) && (n <= N_PHASES_MAX);
    endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Run-cycle and completed-instruction counters for the phase sequencer;
// only instantiated when SEQ_PERF_CNT_EN is defined.
module seq_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        instr_done,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (run) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (instr_done) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// One-hot phase ring with stall, early completion (skip) and halt at the
// instruction boundary. Optional perf counters under SEQ_PERF_CNT_EN.
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int unsigned N_PHASES = 3,
    localparam int unsigned IDX_W    = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                stall,
    input  logic                skip,
    output logic [N_PHASES-1:0] phase,
    output logic [IDX_W-1:0]    phase_idx,
    output logic                instr_done,
    output logic                halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]         cycle_count,
    output logic [31:0]         instr_count
`endif
);

    if (!n_phases_legal(N_PHASES)) begin : g_bad_n_phases
        $error("cpu_phase_sequencer: N_PHASES out of range 2..8");
    end

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PHASES - 1);
    localparam logic [IDX_W-1:0] FETCH_IDX = IDX_W'(PH_FETCH);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_PHASES-1:0] phase_q, phase_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        instr_done = 1'b0;
        case (state_q)
            SEQ_RUN: begin
                if (!stall) begin
                    if ((idx_q == LAST_IDX) || skip) begin
                        instr_done = 1'b1;
                        idx_d      = FETCH_IDX;
                        if (halt) begin
                            state_d = SEQ_HALTED;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SEQ_HALTED: begin
                idx_d = FETCH_IDX;
                if (!halt) begin
                    state_d = SEQ_RUN;
                end
            end
            default: begin
                state_d = SEQ_RUN;
                idx_d   = FETCH_IDX;
            end
        endcase
        // Phase is kept as its own register so the enables leave a flop directly.
        phase_d = (state_d == SEQ_RUN) ? (N_PHASES'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_RUN;
            idx_q   <= FETCH_IDX;
            phase_q <= N_PHASES'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign phase     = phase_q;
    assign phase_idx = idx_q;
    assign halted    = (state_q == SEQ_HALTED);

    a_phase_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(phase) && ((phase == '0) == halted));

`ifdef SEQ_PERF_CNT_EN
    seq_perf_counter u_perf (
        .clk         (clk),
        .reset       (reset),
        .run         (state_q == SEQ_RUN),
        .instr_done  (instr_done),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed-vector bench for cpu_phase_sequencer (N_PHASES=3) with a
// scoreboard queue; perf counters are checked when SEQ_PERF_CNT_EN is set.
module tb_cpu_phase_sequencer;

    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         halt = 1'b0;
    logic         stall = 1'b0;
    logic         skip = 1'b0;
    logic [N-1:0] phase;
    logic [1:0]   phase_idx;
    logic         instr_done;
    logic         halted;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]  cycle_count;
    logic [31:0]  instr_count;
`endif

    cpu_phase_sequencer #(.N_PHASES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .stall       (stall),
        .skip        (skip),
        .phase       (phase),
        .phase_idx   (phase_idx),
        .instr_done  (instr_done),
        .halted      (halted)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, h, st, sk;
        int   idx;
        logic hl, d, chk, cnt;
        int   cyc, ins;
    } vec_t;

    typedef struct {
        int          row;
        logic [2:0]  phase;
        logic [1:0]  idx;
        logic        done;
        logic        halted;
        logic        cnt;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
        end
    endtask

    task automatic add(input logic rst, input logic h, input logic st, input logic sk,
                       input int idx, input logic hl, input logic d);
        vec_t v;
        v.rst = rst; v.h = h; v.st = st; v.sk = sk;
        v.idx = idx; v.hl = hl; v.d = d;
        v.chk = 1'b1; v.cnt = 1'b0; v.cyc = 0; v.ins = 0;
        vecs.push_back(v);
    endtask

    task automatic add_cnt(input logic h, input int idx, input int cyc, input int ins);
        vec_t v;
        v.rst = 1'b0; v.h = h; v.st = 1'b0; v.sk = 1'b0;
        v.idx = idx; v.hl = 1'b0; v.d = 1'b0;
        v.chk = 1'b1; v.cnt = 1'b1; v.cyc = cyc; v.ins = ins;
        vecs.push_back(v);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("phase", e.row, 32'(phase), 32'(e.phase));
            check("phase_idx", e.row, 32'(phase_idx), 32'(e.idx));
            check("instr_done", e.row, 32'(instr_done), 32'(e.done));
            check("halted", e.row, 32'(halted), 32'(e.halted));
`ifdef SEQ_PERF_CNT_EN
            if (e.cnt) begin
                check("cycle_count", e.row, cycle_count, e.cyc);
                check("instr_count", e.row, instr_count, e.ins);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t e;
        //    rst h st sk idx hl d
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
        // free run: done on every third cycle
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, i % 3, 0, (i % 3) == 2);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 1);   // skip in phase 1
        add(0, 0, 1, 1, 0, 0, 0);   // stall+skip in FETCH
        add(0, 0, 0, 1, 0, 0, 1);   // skip in FETCH
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0);   // stall masks skip and halt
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);   // halt raised mid-instruction
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 1, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 2, 0, 1);   // halt dropped before completion
        add(0, 1, 0, 1, 0, 0, 1);   // halt at skip completion
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1, 0);   // reset while halted
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 2, 0, 0);
        add(1, 0, 1, 0, 2, 0, 0);   // reset while stalled in phase 2
        add_cnt(0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 2, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add_cnt(0, 0, 10, 3);

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            @(posedge clk);
            #1;
            reset = v.rst;
            halt  = v.h;
            stall = v.st;
            skip  = v.sk;
            if (v.chk) begin
                e.row    = r;
                e.idx    = 2'(v.idx);
                e.phase  = v.hl ? 3'b000 : (3'b001 << v.idx);
                e.done   = v.d;
                e.halted = v.hl;
                e.cnt    = v.cnt;
                e.cyc    = 32'(v.cyc);
                e.ins    = 32'(v.ins);
                exp_q.push_back(e);
            end
        end
        repeat (2) @(posedge clk);
        check("scoreboard_drain", vecs.size(), 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
